// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bus of the asynchronous FIFO: producer request, read-domain Gray pointer,
// and the pointer/flag outputs. almost_full exists only when ASYNC_FIFO_AF_EN is defined.
interface async_fifo_wr_ctrl_if #(
  parameter int PTR_LEN = 4
) ();
  logic               wr_en;
  logic [PTR_LEN:0]   rd_gray;
  logic [PTR_LEN:0]   wrt_ptr;
  logic [PTR_LEN:0]   wr_gray;
  logic               full;
`ifdef ASYNC_FIFO_AF_EN
  logic               almost_full;
`endif

  modport master (
    output wr_en,
    output rd_gray,
    input  wrt_ptr,
    input  wr_gray,
`ifdef ASYNC_FIFO_AF_EN
    input  almost_full,
`endif
    input  full
  );

  modport slave (
    input  wr_en,
    input  rd_gray,
    output wrt_ptr,
    output wr_gray,
`ifdef ASYNC_FIFO_AF_EN
    output almost_full,
`endif
    output full
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: binary + Gray write pointer,
// 2-flop read-pointer synchronizer, registered full. Optional almost_full via ASYNC_FIFO_AF_EN.
module async_fifo_wr_ctrl #(
  parameter int PTR_LEN  = 4,
  parameter int AF_LEVEL = (1 << PTR_LEN) - 2
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  async_fifo_wr_ctrl_if.slave  bus
);

  // Top two Gray bits inverted marks "writer exactly one lap ahead of reader".
  localparam logic [PTR_LEN:0] WRAP_MASK = (PTR_LEN+1)'(3) << (PTR_LEN - 1);

  if (AF_LEVEL < 1 || AF_LEVEL > (1 << PTR_LEN)) begin : g_bad_af_level
    $error("async_fifo_wr_ctrl: AF_LEVEL out of range 1..2**PTR_LEN");
  end

  function automatic logic [PTR_LEN:0] bin2gray(input logic [PTR_LEN:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PTR_LEN:0] wbin;
  logic [PTR_LEN:0] wr_gray_r;
  logic [PTR_LEN:0] rq1;
  logic [PTR_LEN:0] rq2;
  logic             full_r;
  logic             wr_acc;
  logic [PTR_LEN:0] wbin_next;
  logic [PTR_LEN:0] gray_next;
  logic             full_val;

  assign wr_acc    = bus.wr_en & ~full_r;
  assign wbin_next = wbin + {{PTR_LEN{1'b0}}, wr_acc};
  assign gray_next = bin2gray(wbin_next);
  assign full_val  = (gray_next == (rq2 ^ WRAP_MASK));

  // Read-pointer synchronizer: rd_gray lands directly in rq1, nothing else samples it.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= bus.rd_gray;
      rq2 <= rq1;
    end
  end

  // Pointer and flag register stage, committed on the same edge as the array write.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wbin      <= '0;
      wr_gray_r <= '0;
      full_r    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wbin      <= wbin_next;
        wr_gray_r <= gray_next;
      end
      full_r <= full_val;
    end
  end

  assign bus.wrt_ptr = wbin;
  assign bus.wr_gray = wr_gray_r;
  assign bus.full    = full_r;

`ifdef ASYNC_FIFO_AF_EN
  localparam logic [PTR_LEN+1:0] AF_LVL = (PTR_LEN+2)'(AF_LEVEL);

  function automatic logic [PTR_LEN:0] gray2bin(input logic [PTR_LEN:0] g);
    logic [PTR_LEN:0] b;
    b[PTR_LEN] = g[PTR_LEN];
    for (int i = PTR_LEN - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_LEN:0] rbin_s;
  logic [PTR_LEN:0] lvl;
  logic             af_r;

  assign rbin_s = gray2bin(rq2);
  assign lvl    = wbin_next - rbin_s;

  // Occupancy is one bit wider than the address so a full array reads as 2**PTR_LEN.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      af_r <= 1'b0;
    end else begin
      af_r <= ({1'b0, lvl} >= AF_LVL);
    end
  end

  assign bus.almost_full = af_r;
`endif

endmodule

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO, sitting directly upstream of the dual-clock storage array in the `wr_clk` domain. It does four things:
- Owns the binary write pointer (with wrap bit) that addresses the array.
- Publishes a Gray-coded copy of that pointer for the read domain.
- Synchronises the read domain's Gray pointer into `wr_clk`.
- Generates the registered `full` flag that gates array writes, plus an optional almost-full flag.

## Interface
Parameters:
- `PTR_LEN`, default 4: address bits. Array depth is 2**`PTR_LEN`. Pointers are `PTR_LEN`+1 bits wide; the MSB is the wrap bit.
- `AF_LEVEL`, default 2**`PTR_LEN`-2: occupancy at or above which `almost_full` asserts. Legal range is 1 to 2**`PTR_LEN`.

Ports:
- `wr_clk`  in  1  write-domain clock. This is the only clock.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `wr_clk`.
- `wr_en`  in  1  write request from the producer.
- `rd_gray`  in  `PTR_LEN`+1  read pointer, Gray-coded, launched from a register in the read domain. Asynchronous to `wr_clk`.
- `wrt_ptr`  out  `PTR_LEN`+1  binary write pointer. Drives the array's write-pointer input.
- `wr_gray`  out  `PTR_LEN`+1  registered Gray write pointer, sent to the read domain.
- `full`  out  1  registered full flag. Drives the array's `full` input and the producer.
- `almost_full`  out  1  registered. Present only when `ASYNC_FIFO_AF_EN` is defined.

## Operation
- Write accept: `wr_acc = wr_en & ~full`. This is the same condition the array uses to commit data at `wrt_ptr[PTR_LEN-1:0]` on this edge.
- Pointer update: on each `wr_clk` edge with `wr_acc`:
  - `wbin <= wbin + 1`, modulo 2**(`PTR_LEN`+1).
  - `wr_gray <= (wbin_next >> 1) ^ wbin_next`.
  - `wrt_ptr` equals `wbin`.
- Synchronizer: two-flop chain `rq1 <= rd_gray`, `rq2 <= rq1`.
  - No logic sits between `rd_gray` and `rq1`.
  - `rd_gray` is sampled only by `rq1`.
- Full detection:
  - `full_val = (gray(wbin_next) == {~rq2[P:P-1], rq2[P-2:0]})`, where `P` = `PTR_LEN`.
  - `wbin_next = wbin + wr_acc`.
  - `full <= full_val` every edge.
- Write while full: no pointer change, and `wr_gray` is held.
- Reset (`rst` = 1 at an edge): `wbin`, `wr_gray`, `rq1`, `rq2`, `full` and `almost_full` all go to 0. Reset has priority over `wr_en`.
  - Reset mid-burst discards pointer state.
  - The read side is reset by its own domain logic. The system sequence resets both domains before traffic starts.
- Simultaneous accepted write and read-pointer advance: both take effect. `full` reflects the read advance only once it reaches `rq2`.

## Timing
- `wrt_ptr` and `wr_gray` update on the same edge that commits the data, so the array write and the pointer increment are coincident.
- Assert: `full` asserts on the edge that accepts the write filling the last slot. The next `wr_en` is already blocked.
- Deassert: a `rd_gray` change is visible in `rq2` after 2 edges. `full` deasserts on the 3rd `wr_clk` edge after the change. This pessimistic latency is by design.
- `wr_gray` changes at most 1 bit per `wr_clk` cycle. No combinational path exists from `wr_en` to `wr_gray`.
- Flag latency: `full` and `almost_full` are registered, with no combinational path from any input.

## Configuration
- Macro `ASYNC_FIFO_AF_EN`.
- Defined:
  - Convert `rq2` Gray to binary as `rbin_s`.
  - Compute occupancy `lvl = wbin_next - rbin_s`, `PTR_LEN`+1 bits, unsigned modulo.
  - `almost_full <= (lvl >= AF_LEVEL)`.
  - Deassert latency matches `full`.
- Undefined: the `almost_full` port, the Gray-to-binary converter and the subtractor are absent. `AF_LEVEL` is ignored.

## Test plan
All scenarios use `PTR_LEN`=3.
- Reset values: `rst`=1 for 2 cycles with `wr_en`=1 → `wrt_ptr`=0, `wr_gray`=0, `full`=0 and `almost_full`=0 on every edge.
- Fill: `rd_gray`=0, 8 consecutive `wr_en` cycles →
  - `wrt_ptr` steps 0..8, ending at 4'b1000.
  - `wr_gray` ends at 4'b1100.
  - `full`=1 on the 8th write's edge.
  - With `ASYNC_FIFO_AF_EN`, `almost_full`=1 on the 6th write's edge.
- Blocked write: continue `wr_en`=1 for 4 more cycles while full → `wrt_ptr` stays 8, `wr_gray` stays 4'b1100.
- Read release: from full, drive `rd_gray`=4'b0010 (read binary 3) → `full`=0 on the 3rd edge afterward, then exactly 3 more writes accepted (`wrt_ptr`=11) before `full` reasserts.
- Wrap: keep `rd_gray`=gray(`wbin`-2) for 20 writes → `full` never asserts and `wrt_ptr` wraps 15→0. Check that `wr_gray` changes exactly 1 bit per accepted write, including at the wrap.
- Reset mid-operation: assert `rst` with `wrt_ptr`=5 and `full`=0 → all outputs 0 on the next edge, and the first write afterward addresses slot 0.
